// File: rtl/motor_pwm_driver.sv
// Motor PWM driver: signed duty request to H-bridge PWM with
// per-period slew limiting and whole-period reversal dead time.
module motor_pwm_driver (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               update_controller,
    input  logic signed [15:0] pwmRef,
    input  logic        [15:0] period,
    input  logic        [7:0]  deadTime,
    input  logic        [15:0] slewStep,
    output logic               pwm_a,
    output logic               pwm_b,
    output logic               dir,
    output logic signed [15:0] duty,
    output logic        [1:0]  state
);
    localparam logic [1:0] S_DIS = 2'd0;
    localparam logic [1:0] S_RUN = 2'd1;
    localparam logic [1:0] S_DT  = 2'd2;

    logic        [15:0] cnt_q, cnt_d;
    logic signed [15:0] tgt_q, tgt_d;
    logic        [15:0] mag_q, mag_d;
    logic        [7:0]  dt_q, dt_d;
    logic               dir_q, dir_d;
    logic        [1:0]  st_q, st_d;
    logic               upd_q;
    logic               pa_q, pa_d;
    logic               pb_q, pb_d;

    logic        per_ok, tick, unl, oppose;
    logic [15:0] tabs, tmag, ramp, shrink;

    assign per_ok = (period >= 16'd2);
    assign tick   = per_ok && (cnt_q >= period - 16'd1);
    assign unl    = (slewStep == 16'd0);
    assign oppose = (tgt_q != 16'sd0) && (tgt_q[15] != dir_q);

    // -32768 saturates to 32767 so the magnitude fits 15 bits
    always_comb begin
        tabs = $unsigned(tgt_q);
        if (tgt_q[15])
            tabs = (tgt_q == 16'sh8000) ? 16'h7fff
                 : 16'(~tgt_q) + 16'd1;
        tmag = (tabs > period) ? period : tabs;
    end

    always_comb begin
        if (mag_q < tmag)
            ramp = (unl || (tmag - mag_q) <= slewStep)
                 ? tmag : mag_q + slewStep;
        else
            ramp = (unl || (mag_q - tmag) <= slewStep)
                 ? tmag : mag_q - slewStep;
        shrink = (unl || mag_q <= slewStep)
               ? 16'd0 : mag_q - slewStep;
    end

    always_comb begin
        cnt_d = (per_ok && !tick) ? cnt_q + 16'd1 : 16'd0;
        tgt_d = (update_controller && !upd_q) ? pwmRef : tgt_q;
        mag_d = mag_q;
        dt_d  = dt_q;
        dir_d = dir_q;
        st_d  = st_q;
        if (!enable) begin
            st_d  = S_DIS;
            mag_d = 16'd0;
        end else begin
            unique case (st_q)
                S_DIS: st_d = S_RUN;
                S_RUN: begin
                    if (tick) begin
                        if (!oppose) begin
                            mag_d = ramp;
                        end else if (mag_q != 16'd0) begin
                            mag_d = shrink;
                        end else if (deadTime != 8'd0) begin
                            st_d = S_DT;
                            dt_d = deadTime;
                        end else begin
                            dir_d = ~dir_q;
                        end
                    end
                end
                S_DT: begin
                    if (tick) begin
                        if (dt_q <= 8'd1) begin
                            st_d  = S_RUN;
                            dir_d = ~dir_q;
                            mag_d = 16'd0;
                            dt_d  = 8'd0;
                        end else begin
                            dt_d = dt_q - 8'd1;
                        end
                    end
                end
                default: st_d = S_DIS;
            endcase
        end
        // one-cycle-late compare keeps the outputs registered
        pa_d = per_ok && (st_q == S_RUN) && !dir_q
            && (cnt_q < mag_q);
        pb_d = per_ok && (st_q == S_RUN) && dir_q
            && (cnt_q < mag_q);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= 16'd0;
            tgt_q <= 16'sd0;
            mag_q <= 16'd0;
            dt_q  <= 8'd0;
            dir_q <= 1'b0;
            st_q  <= S_DIS;
            upd_q <= 1'b0;
            pa_q  <= 1'b0;
            pb_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tgt_q <= tgt_d;
            mag_q <= mag_d;
            dt_q  <= dt_d;
            dir_q <= dir_d;
            st_q  <= st_d;
            upd_q <= update_controller;
            pa_q  <= pa_d;
            pb_q  <= pb_d;
        end
    end

    assign pwm_a = pa_q;
    assign pwm_b = pb_q;
    assign dir   = dir_q;
    assign duty  = dir_q ? -$signed(mag_q) : $signed(mag_q);
    assign state = st_q;
endmodule

// File: tb/tb_motor_pwm_driver.sv
// Bench for motor_pwm_driver: directed scenarios plus random
// stimulus, checked every cycle against a behavioural model.
module tb_motor_pwm_driver;
    logic               clock = 1'b0;
    logic               reset;
    logic               enable;
    logic               update_controller;
    logic signed [15:0] pwmRef;
    logic        [15:0] period;
    logic        [7:0]  deadTime;
    logic        [15:0] slewStep;
    logic               pwm_a;
    logic               pwm_b;
    logic               dir;
    logic signed [15:0] duty;
    logic        [1:0]  state;

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;
    bit prev_a = 1'b0;
    bit prev_b = 1'b0;

    int exp_duty[12] = '{40, 30, 20, 10, 0, 0, 0, 0,
                         0, -10, -20, -30};
    int exp_st[12]   = '{1, 1, 1, 1, 1, 2, 2, 2,
                         1, 1, 1, 1};
    int plist[8]     = '{0, 1, 2, 3, 4, 7, 12, 25};

    motor_pwm_driver dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .update_controller(update_controller),
        .pwmRef(pwmRef),
        .period(period),
        .deadTime(deadTime),
        .slewStep(slewStep),
        .pwm_a(pwm_a),
        .pwm_b(pwm_b),
        .dir(dir),
        .duty(duty),
        .state(state)
    );

    always #5 clock = ~clock;

    typedef struct {
        int cnt;
        int tgt;
        int mag;
        bit dir;
        int st;
        int dt;
        bit upd;
        bit pa;
        bit pb;
    } m_t;

    m_t mdl = '{default: 0};

    // Next model state from the requirement rules, integer arithmetic
    function automatic m_t step(m_t m, bit rst, bit en, bit upd,
                                int rv, int per, int dtm, int slw);
        m_t n;
        int a;
        bit tk;
        bit opp;
        n = m;
        if (rst) begin
            n = '{default: 0};
            return n;
        end
        tk = (per >= 2) && (m.cnt >= per - 1);
        n.pa = (per >= 2) && m.st == 1 && !m.dir && m.cnt < m.mag;
        n.pb = (per >= 2) && m.st == 1 && m.dir && m.cnt < m.mag;
        n.cnt = (per < 2 || tk) ? 0 : m.cnt + 1;
        n.upd = upd;
        if (upd && !m.upd) n.tgt = rv;
        a = (m.tgt < 0) ? -m.tgt : m.tgt;
        if (a > 32767) a = 32767;
        if (a > per) a = per;
        opp = (m.tgt != 0) && ((m.tgt < 0) != m.dir);
        if (!en) begin
            n.st = 0;
            n.mag = 0;
        end else if (m.st == 0) begin
            n.st = 1;
        end else if (tk && m.st == 1) begin
            if (!opp) begin
                if (slw == 0) n.mag = a;
                else if (m.mag < a)
                    n.mag = (m.mag + slw > a) ? a : m.mag + slw;
                else
                    n.mag = (m.mag - slw < a) ? a : m.mag - slw;
            end else if (m.mag > 0) begin
                n.mag = (slw == 0 || m.mag - slw < 0) ? 0 : m.mag - slw;
            end else if (dtm > 0) begin
                n.st = 2;
                n.dt = dtm;
            end else begin
                n.dir = !m.dir;
            end
        end else if (tk && m.st == 2) begin
            if (m.dt == 1) begin
                n.st = 1;
                n.dir = !m.dir;
                n.dt = 0;
            end else begin
                n.dt = m.dt - 1;
            end
        end
        return n;
    endfunction

    always @(posedge clock)
        mdl <= step(mdl, reset, enable, update_controller,
                    int'(pwmRef), int'(period), int'(deadTime),
                    int'(slewStep));

    always @(negedge clock) begin
        int ed;
        if (chk_on) begin
            ed = mdl.dir ? -mdl.mag : mdl.mag;
            tests++;
            if (pwm_a !== mdl.pa || pwm_b !== mdl.pb
                || dir !== mdl.dir || int'(duty) != ed
                || int'(state) != mdl.st) begin
                fails++;
                $display("FAIL model t=%0t got a=%b b=%b dir=%b duty=%0d st=%0d want a=%b b=%b dir=%b duty=%0d st=%0d",
                         $time, pwm_a, pwm_b, dir, duty, state,
                         mdl.pa, mdl.pb, mdl.dir, ed, mdl.st);
            end
            tests++;
            if (pwm_a === 1'b1 && pwm_b === 1'b1) begin
                fails++;
                $display("FAIL overlap t=%0t got a=1 b=1 want not both",
                         $time);
            end
            tests++;
            if ((pwm_b === 1'b1 && prev_a) || (pwm_a === 1'b1 && prev_b)) begin
                fails++;
                $display("FAIL gap t=%0t got a=%b b=%b after a=%b b=%b want a low cycle",
                         $time, pwm_a, pwm_b, prev_a, prev_b);
            end
            prev_a = (pwm_a === 1'b1);
            prev_b = (pwm_b === 1'b1);
        end
    end

    task automatic check(string nm, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_cnt(int k);
        int i;
        i = 0;
        while (mdl.cnt != k && i < 5000) begin
            @(negedge clock);
            i++;
        end
        if (mdl.cnt != k) check("wait_cnt_timeout", mdl.cnt, k);
    endtask

    task automatic next_tick();
        @(negedge clock);
        wait_cnt(0);
    endtask

    task automatic pulse(int v);
        pwmRef = 16'(v);
        update_controller = 1'b1;
        @(negedge clock);
        update_controller = 1'b0;
    endtask

    initial begin
        int na;
        int nb;
        int r;
        reset = 1'b1;
        enable = 1'b0;
        update_controller = 1'b0;
        pwmRef = 16'sd0;
        period = 16'd100;
        deadTime = 8'd0;
        slewStep = 16'd0;
        cyc(3);
        chk_on = 1'b1;
        check("rst_state", int'(state), 0);
        check("rst_duty", int'(duty), 0);
        check("rst_dir", int'(dir), 0);
        check("rst_pwm_a", int'(pwm_a), 0);
        check("rst_pwm_b", int'(pwm_b), 0);
        reset = 1'b0;

        enable = 1'b1;
        cyc(2);
        pulse(40);
        next_tick();
        check("duty40", int'(duty), 40);
        na = 0;
        nb = 0;
        for (int i = 0; i < 100; i++) begin
            na += int'(pwm_a);
            nb += int'(pwm_b);
            @(negedge clock);
        end
        check("a_high_of_100", na, 40);
        check("b_high_of_100", nb, 0);

        pulse(7);
        wait_cnt(50);
        period = 16'd10;
        @(negedge clock);
        check("shrink_wrap_duty", int'(duty), 7);
        period = 16'd100;
        wait_cnt(2);
        check("pwm_a_on", int'(pwm_a), 1);
        enable = 1'b0;
        cyc(2);
        check("dis_pwm_a", int'(pwm_a), 0);
        check("dis_state", int'(state), 0);
        check("dis_duty", int'(duty), 0);

        slewStep = 16'd10;
        pulse(40);
        enable = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            next_tick();
            check("reenable_ramp", int'(duty), 10 * k);
        end

        pulse(50);
        next_tick();
        check("ramp50", int'(duty), 50);
        deadTime = 8'd3;
        pulse(-30);
        for (int k = 0; k < 12; k++) begin
            next_tick();
            check("rev_duty", int'(duty), exp_duty[k]);
            check("rev_state", int'(state), exp_st[k]);
        end
        check("rev_dir", int'(dir), 1);

        pulse(20);
        next_tick();
        next_tick();
        next_tick();
        next_tick();
        check("dt_entered", int'(state), 2);
        cyc(30);
        reset = 1'b1;
        @(negedge clock);
        check("dtrst_state", int'(state), 0);
        check("dtrst_dir", int'(dir), 0);
        check("dtrst_a", int'(pwm_a), 0);
        check("dtrst_b", int'(pwm_b), 0);
        check("dtrst_duty", int'(duty), 0);
        period = 16'd1000;
        slewStep = 16'd0;
        deadTime = 8'd1;
        reset = 1'b0;

        pulse(-32768);
        next_tick();
        check("sat_dt", int'(state), 2);
        next_tick();
        next_tick();
        check("sat_duty", int'(duty), -1000);
        @(negedge clock);
        na = 0;
        nb = 0;
        for (int i = 0; i < 1000; i++) begin
            na += int'(pwm_a);
            nb += int'(pwm_b);
            @(negedge clock);
        end
        check("sat_b_high", nb, 1000);
        check("sat_a_high", na, 0);

        period = 16'd200;
        cyc(2);
        pwmRef = -16'sd60;
        update_controller = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clock);
            pwmRef = 16'(11 * i);
        end
        @(negedge clock);
        update_controller = 1'b0;
        next_tick();
        check("edge_capture", int'(duty), -60);

        period = 16'd1;
        pulse(-5);
        na = 0;
        for (int i = 0; i < 20; i++) begin
            na += int'(pwm_a) + int'(pwm_b);
            @(negedge clock);
        end
        check("per1_pwm_low", na, 0);
        check("per1_duty_hold", int'(duty), -60);

        period = 16'd12;
        for (int i = 0; i < 20000; i++) begin
            reset = ($urandom_range(0, 1999) == 0);
            if ($urandom_range(0, 199) == 0) enable = !enable;
            if ($urandom_range(0, 299) == 0)
                period = 16'(plist[$urandom_range(0, 7)]);
            if ($urandom_range(0, 99) == 0)
                deadTime = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0)
                slewStep = 16'($urandom_range(0, 6));
            if ($urandom_range(0, 7) == 0)
                update_controller = !update_controller;
            r = int'($urandom_range(0, 19));
            if (r == 0) pwmRef = 16'h8000;
            else if (r == 1) pwmRef = 16'sh7fff;
            else if (r == 2) pwmRef = 16'sd0;
            else pwmRef = 16'($urandom_range(0, 60)) - 16'd30;
            @(negedge clock);
        end
        reset = 1'b0;
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
